// File: rtl/ppu_ctrl_pipeline_if.sv
// Fetch-to-decode handshake for the PPU control pipe.
// Fetch drives the instruction; decode returns id_ready.
interface ppu_ctrl_pipeline_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;

    modport master (
        output if_valid,
        output if_instr,
        input  id_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        output id_ready
    );
endinterface

// File: rtl/ppu_ctrl_pipeline.sv
// PPU control decode plus STAGES-deep control pipe with load-use bubbles.
// Trap-class decode is enabled by defining PPU_CTRL_TRAP_EN.
module ppu_ctrl_pipeline #(
    parameter int STAGES = 3,
    parameter int CW_W   = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    ppu_ctrl_pipeline_if.slave       fe,
    input  logic                     stall_ext,
    input  logic                     flush,
    output logic                     hazard_stall,
    output logic [STAGES*CW_W-1:0]   stg_ctrl,
    output logic [STAGES*5-1:0]      stg_dest,
    output logic [STAGES-1:0]        stg_valid,
    output logic                     illegal,
    output logic                     trap
);

    if (CW_W != 18) begin : g_bad_cw
        $error("ppu_ctrl_pipeline: CW_W must be 18");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("ppu_ctrl_pipeline: STAGES must be 2..4");
    end

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] fn;

    assign op = fe.if_instr[31:26];
    assign rs = fe.if_instr[25:21];
    assign rt = fe.if_instr[20:16];
    assign rd = fe.if_instr[15:11];
    assign fn = fe.if_instr[5:0];

    logic [2:0]      so_sel;
    logic [3:0]      alu_op;
    logic            b_instr;
    logic            load;
    logic            rf_en;
    logic            ta_instr;
    logic [1:0]      mem_size;
    logic            mem_rw;
    logic            mem_se;
    logic            mem_en;
    logic            hi_en;
    logic            lo_en;
    logic [4:0]      dst_raw;
    logic            reads_rt;
    logic            dec_ill;
    logic            dec_trap;
    logic [CW_W-1:0] dec_cw;
    logic [4:0]      dec_dest;

    // Instruction decode into individual control fields
    always_comb begin
        so_sel   = 3'b000;
        alu_op   = 4'b0000;
        b_instr  = 1'b0;
        load     = 1'b0;
        rf_en    = 1'b0;
        ta_instr = 1'b0;
        mem_size = 2'b00;
        mem_rw   = 1'b0;
        mem_se   = 1'b0;
        mem_en   = 1'b0;
        hi_en    = 1'b0;
        lo_en    = 1'b0;
        dst_raw  = 5'd0;
        reads_rt = 1'b0;
        dec_ill  = 1'b0;
        dec_trap = 1'b0;
        if (fe.if_instr != 32'h0) begin
            case (op)
                6'h00: begin
                    dst_raw  = rd;
                    reads_rt = 1'b1;
                    case (fn)
                        6'h00: begin so_sel = 3'b011; alu_op = 4'b1000; rf_en = 1'b1; end
                        6'h02: begin so_sel = 3'b011; alu_op = 4'b1001; rf_en = 1'b1; end
                        6'h03: begin so_sel = 3'b011; alu_op = 4'b1010; rf_en = 1'b1; end
                        6'h08: begin b_instr = 1'b1; reads_rt = 1'b0; end
                        6'h09: begin
                            b_instr  = 1'b1;
                            ta_instr = 1'b1;
                            rf_en    = 1'b1;
                            reads_rt = 1'b0;
                        end
                        6'h10: begin alu_op = 4'b1100; rf_en = 1'b1; reads_rt = 1'b0; end
                        6'h11: begin hi_en = 1'b1; reads_rt = 1'b0; end
                        6'h12: begin alu_op = 4'b1101; rf_en = 1'b1; reads_rt = 1'b0; end
                        6'h13: begin lo_en = 1'b1; reads_rt = 1'b0; end
                        6'h20, 6'h21: rf_en = 1'b1;
                        6'h22, 6'h23: begin alu_op = 4'b0001; rf_en = 1'b1; end
                        6'h24: begin alu_op = 4'b0010; rf_en = 1'b1; end
                        6'h25: begin alu_op = 4'b0011; rf_en = 1'b1; end
                        6'h26: begin alu_op = 4'b0100; rf_en = 1'b1; end
                        6'h27: begin alu_op = 4'b0101; rf_en = 1'b1; end
                        6'h2A: begin alu_op = 4'b0110; rf_en = 1'b1; end
                        6'h2B: begin alu_op = 4'b0111; rf_en = 1'b1; end
`ifdef PPU_CTRL_TRAP_EN
                        6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36: begin
                            alu_op   = 4'b0001;
                            dec_trap = 1'b1;
                        end
`endif
                        default: dec_ill = 1'b1;
                    endcase
                end
                6'h01: begin
                    case (rt)
                        5'h00, 5'h01: begin b_instr = 1'b1; alu_op = 4'b0001; end
                        5'h10, 5'h11: begin
                            b_instr  = 1'b1;
                            alu_op   = 4'b0001;
                            ta_instr = 1'b1;
                            rf_en    = 1'b1;
                            dst_raw  = 5'd31;
                        end
`ifdef PPU_CTRL_TRAP_EN
                        5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0E: begin
                            so_sel   = 3'b001;
                            alu_op   = 4'b0001;
                            dec_trap = 1'b1;
                        end
`endif
                        default: dec_ill = 1'b1;
                    endcase
                end
                6'h02: b_instr = 1'b1;
                6'h03: begin
                    b_instr  = 1'b1;
                    ta_instr = 1'b1;
                    rf_en    = 1'b1;
                    dst_raw  = 5'd31;
                end
                6'h04, 6'h05: begin b_instr = 1'b1; alu_op = 4'b0001; reads_rt = 1'b1; end
                6'h06, 6'h07: begin b_instr = 1'b1; alu_op = 4'b0001; end
                6'h08, 6'h09: begin so_sel = 3'b001; rf_en = 1'b1; dst_raw = rt; end
                6'h0A: begin so_sel = 3'b001; alu_op = 4'b0110; rf_en = 1'b1; dst_raw = rt; end
                6'h0B: begin so_sel = 3'b001; alu_op = 4'b0111; rf_en = 1'b1; dst_raw = rt; end
                6'h0C: begin so_sel = 3'b010; alu_op = 4'b0010; rf_en = 1'b1; dst_raw = rt; end
                6'h0D: begin so_sel = 3'b010; alu_op = 4'b0011; rf_en = 1'b1; dst_raw = rt; end
                6'h0E: begin so_sel = 3'b010; alu_op = 4'b0100; rf_en = 1'b1; dst_raw = rt; end
                6'h0F: begin so_sel = 3'b100; alu_op = 4'b1011; rf_en = 1'b1; dst_raw = rt; end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    so_sel   = 3'b001;
                    load     = 1'b1;
                    rf_en    = 1'b1;
                    mem_en   = 1'b1;
                    dst_raw  = rt;
                    mem_size = (op[1:0] == 2'b11) ? 2'b10 : {1'b0, op[0]};
                    mem_se   = ~op[2] & (op[1:0] != 2'b11);
                end
                6'h28, 6'h29, 6'h2B: begin
                    so_sel   = 3'b001;
                    mem_en   = 1'b1;
                    mem_rw   = 1'b1;
                    reads_rt = 1'b1;
                    mem_size = (op[1:0] == 2'b11) ? 2'b10 : {1'b0, op[0]};
                end
                default: dec_ill = 1'b1;
            endcase
        end
        dec_cw = {so_sel, alu_op, b_instr, load, rf_en, ta_instr,
                  mem_size, mem_rw, mem_se, mem_en, hi_en, lo_en};
        dec_dest = rf_en ? dst_raw : 5'd0;
    end

    logic [CW_W-1:0] ctrl_q  [STAGES];
    logic [4:0]      dest_q  [STAGES];
    logic            valid_q [STAGES];
    logic            illegal_q;
    logic            hz_raw;
    logic            ld0;
    logic            bubble0;

    // Load in stage 0 whose destination feeds the instruction in ID
    always_comb begin
        hz_raw = valid_q[0] & ctrl_q[0][9] & (dest_q[0] != 5'd0) &
                 ((dest_q[0] == rs) | (reads_rt & (dest_q[0] == rt)));
        hazard_stall = hz_raw & ~stall_ext & ~flush;
        fe.id_ready  = flush | (~stall_ext & ~hz_raw);
        ld0     = flush | ~stall_ext;
        bubble0 = flush | hz_raw | ~fe.if_valid;
    end

    // Control pipe registers: stage 0 from decode, stage k from stage k-1
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k]  <= '0;
                dest_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
            illegal_q <= 1'b0;
        end else begin
            if (!stall_ext) begin
                for (int k = 1; k < STAGES; k++) begin
                    ctrl_q[k]  <= ctrl_q[k-1];
                    dest_q[k]  <= dest_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
            if (ld0) begin
                ctrl_q[0]  <= bubble0 ? '0 : dec_cw;
                dest_q[0]  <= bubble0 ? 5'd0 : dec_dest;
                valid_q[0] <= ~bubble0;
                illegal_q  <= ~bubble0 & dec_ill;
            end
        end
    end

`ifdef PPU_CTRL_TRAP_EN
    logic trap_q;

    // Trap flag follows the same accept/bubble rule as illegal
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (ld0) begin
            trap_q <= ~bubble0 & dec_trap;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign illegal = illegal_q;

    // Flatten per-stage registers onto the output buses
    always_comb begin
        stg_ctrl  = '0;
        stg_dest  = '0;
        stg_valid = '0;
        for (int k = 0; k < STAGES; k++) begin
            stg_ctrl[k*CW_W +: CW_W] = ctrl_q[k];
            stg_dest[k*5 +: 5]       = dest_q[k];
            stg_valid[k]             = valid_q[k];
        end
    end

endmodule

// File: tb/tb_ppu_ctrl_pipeline.sv
// Directed bench for ppu_ctrl_pipeline (STAGES = 3).
// Table of decode vectors plus hand-written pipeline sequences.
module tb_ppu_ctrl_pipeline;

    localparam int S = 3;

    logic           clk;
    logic           reset;
    logic           stall_ext;
    logic           flush;
    logic           hazard_stall;
    logic [S*18-1:0] stg_ctrl;
    logic [S*5-1:0] stg_dest;
    logic [S-1:0]   stg_valid;
    logic           illegal;
    logic           trap;

    ppu_ctrl_pipeline_if fe ();

    ppu_ctrl_pipeline #(.STAGES(S), .CW_W(18)) dut (
        .clk          (clk),
        .reset        (reset),
        .fe           (fe),
        .stall_ext    (stall_ext),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .stg_ctrl     (stg_ctrl),
        .stg_dest     (stg_dest),
        .stg_valid    (stg_valid),
        .illegal      (illegal),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] ADDU3  = 32'h0022_1821;
    localparam logic [31:0] SUBU7  = 32'h0022_3823;
    localparam logic [31:0] LW4    = 32'h8CA4_0000;
    localparam logic [31:0] LW0    = 32'h8CA0_0000;
    localparam logic [31:0] ADDU_D = 32'h0081_3021;
    localparam logic [31:0] ADDU_Z = 32'h0001_3021;
    localparam logic [31:0] JAL    = 32'h0C00_0010;
    localparam logic [31:0] MTHI   = 32'h00A0_0011;
    localparam logic [17:0] LW_MSK = 18'h38374;
    localparam logic [17:0] LW_CW  = 18'h08344;

    typedef struct {
        logic [31:0] instr;
        logic [17:0] mask;
        logic [17:0] cw;
        logic [4:0]  dest;
        logic        ill;
        logic        trp;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] cw(input int k);
        return stg_ctrl[k*18 +: 18];
    endfunction

    function automatic logic [4:0] ds(input int k);
        return stg_dest[k*5 +: 5];
    endfunction

    task automatic drv(input logic v, input logic [31:0] ins,
                       input logic st, input logic fl);
        fe.if_valid = v;
        fe.if_instr = ins;
        stall_ext   = st;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ramp [4];
        ramp[0] = 3'b001;
        ramp[1] = 3'b011;
        ramp[2] = 3'b111;
        ramp[3] = 3'b111;

        vt[0]  = '{NOP,          18'h3FFFF, 18'h00000, 5'd0,  1'b0, 1'b0};
        vt[1]  = '{ADDU3,        18'h3FFFF, 18'h00100, 5'd3,  1'b0, 1'b0};
        vt[2]  = '{SUBU7,        18'h07900, 18'h00900, 5'd7,  1'b0, 1'b0};
        vt[3]  = '{LW4,          LW_MSK,    LW_CW,     5'd4,  1'b0, 1'b0};
        vt[4]  = '{32'h80A90000, 18'h00368, 18'h00308, 5'd9,  1'b0, 1'b0};
        vt[5]  = '{32'h90A90000, 18'h00368, 18'h00300, 5'd9,  1'b0, 1'b0};
        vt[6]  = '{32'hACA40008, 18'h00374, 18'h00054, 5'd0,  1'b0, 1'b0};
        vt[7]  = '{JAL,          18'h00180, 18'h00180, 5'd31, 1'b0, 1'b0};
        vt[8]  = '{32'h04B10004, 18'h00180, 18'h00180, 5'd31, 1'b0, 1'b0};
        vt[9]  = '{32'h04B00004, 18'h00180, 18'h00180, 5'd31, 1'b0, 1'b0};
        vt[10] = '{MTHI,         18'h00103, 18'h00002, 5'd0,  1'b0, 1'b0};
        vt[11] = '{32'h00A00013, 18'h00103, 18'h00001, 5'd0,  1'b0, 1'b0};
        vt[12] = '{32'hFC000000, 18'h3FFFF, 18'h00000, 5'd0,  1'b1, 1'b0};
        vt[13] = '{32'h0000003F, 18'h3FFFF, 18'h00000, 5'd0,  1'b1, 1'b0};
`ifdef PPU_CTRL_TRAP_EN
        vt[14] = '{32'h00220034, 18'h3F900, 18'h00800, 5'd0,  1'b0, 1'b1};
`else
        vt[14] = '{32'h00220034, 18'h3FFFF, 18'h00000, 5'd0,  1'b1, 1'b0};
`endif

        reset = 1'b1;
        drv(1'b0, NOP, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 64'(stg_valid), 64'd0);
        chk("rst_ctrl", 64'(stg_ctrl), 64'd0);
        chk("rst_dest", 64'(stg_dest), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);

        reset = 1'b0;
        drv(1'b1, NOP, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nop_valid_ramp", 64'(stg_valid), 64'(ramp[i]));
            chk("nop_ctrl", 64'(stg_ctrl), 64'd0);
            chk("nop_illegal", 64'(illegal), 64'd0);
        end

        drv(1'b1, ADDU3, 1'b0, 1'b0);
        tick();
        chk("shift_s0_cw", 64'(cw(0)), 64'h100);
        chk("shift_s0_dest", 64'(ds(0)), 64'd3);
        drv(1'b1, NOP, 1'b0, 1'b0);
        tick();
        chk("shift_s1_cw", 64'(cw(1)), 64'h100);
        tick();
        chk("shift_s2_cw", 64'(cw(2)), 64'h100);
        chk("shift_s2_dest", 64'(ds(2)), 64'd3);

        drv(1'b1, LW4, 1'b0, 1'b0);
        tick();
        drv(1'b1, ADDU_D, 1'b0, 1'b0);
        chk("lu_hazard", 64'(hazard_stall), 64'd1);
        chk("lu_id_ready", 64'(fe.id_ready), 64'd0);
        tick();
        chk("lu_bubble_valid", 64'(stg_valid[0]), 64'd0);
        chk("lu_bubble_cw", 64'(cw(0)), 64'd0);
        chk("lu_s1_lw", 64'(cw(1) & LW_MSK), 64'(LW_CW));
        chk("lu_hazard_gone", 64'(hazard_stall), 64'd0);
        chk("lu_ready_back", 64'(fe.id_ready), 64'd1);
        tick();
        chk("lu_consumer_cw", 64'(cw(0)), 64'h100);
        chk("lu_consumer_dest", 64'(ds(0)), 64'd6);
        chk("lu_s2_lw_dest", 64'(ds(2)), 64'd4);

        drv(1'b1, LW0, 1'b0, 1'b0);
        tick();
        drv(1'b1, ADDU_Z, 1'b0, 1'b0);
        chk("lu0_no_hazard", 64'(hazard_stall), 64'd0);
        chk("lu0_ready", 64'(fe.id_ready), 64'd1);
        tick();
        chk("lu0_consumer_dest", 64'(ds(0)), 64'd6);

        drv(1'b1, ADDU3, 1'b0, 1'b0);
        tick();
        drv(1'b1, SUBU7, 1'b0, 1'b0);
        tick();
        drv(1'b1, JAL, 1'b0, 1'b0);
        tick();
        drv(1'b1, MTHI, 1'b1, 1'b0);
        chk("stall_id_ready", 64'(fe.id_ready), 64'd0);
        chk("stall_hazard", 64'(hazard_stall), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_dest", 64'(stg_dest), 64'({5'd3, 5'd7, 5'd31}));
            chk("stall_hold_valid", 64'(stg_valid), 64'd7);
        end
        drv(1'b1, MTHI, 1'b0, 1'b0);
        tick();
        chk("stall_resume_dest", 64'(stg_dest), 64'({5'd7, 5'd31, 5'd0}));
        chk("stall_resume_cw", 64'(cw(0) & 18'h00103), 64'h002);

        drv(1'b1, LW4, 1'b0, 1'b0);
        tick();
        drv(1'b1, ADDU_D, 1'b1, 1'b0);
        chk("stall_hz_masked", 64'(hazard_stall), 64'd0);
        chk("stall_hz_ready", 64'(fe.id_ready), 64'd0);
        drv(1'b1, ADDU_D, 1'b0, 1'b1);
        chk("flush_hz_stall", 64'(hazard_stall), 64'd0);
        chk("flush_hz_ready", 64'(fe.id_ready), 64'd1);
        tick();
        chk("flush_s0_valid", 64'(stg_valid[0]), 64'd0);
        chk("flush_s0_cw", 64'(cw(0)), 64'd0);
        chk("flush_s1_dest", 64'(ds(1)), 64'd4);

        drv(1'b1, ADDU3, 1'b0, 1'b0);
        tick();
        drv(1'b1, SUBU7, 1'b1, 1'b1);
        chk("flstall_ready", 64'(fe.id_ready), 64'd1);
        tick();
        chk("flstall_valid", 64'(stg_valid), 64'b100);
        chk("flstall_dest", 64'(stg_dest), 64'({5'd4, 5'd0, 5'd0}));

        for (int i = 0; i < 15; i++) begin
            drv(1'b1, vt[i].instr, 1'b0, 1'b0);
            chk("vec_ready", 64'(fe.id_ready), 64'd1);
            tick();
            chk($sformatf("vec%0d_cw", i), 64'(cw(0) & vt[i].mask),
                64'(vt[i].cw));
            chk($sformatf("vec%0d_dest", i), 64'(ds(0)), 64'(vt[i].dest));
            chk($sformatf("vec%0d_valid", i), 64'(stg_valid[0]), 64'd1);
            chk($sformatf("vec%0d_illegal", i), 64'(illegal), 64'(vt[i].ill));
            chk($sformatf("vec%0d_trap", i), 64'(trap), 64'(vt[i].trp));
            drv(1'b1, NOP, 1'b0, 1'b0);
            tick();
            chk($sformatf("vec%0d_ill_drop", i), 64'(illegal), 64'd0);
        end

        drv(1'b1, ADDU3, 1'b0, 1'b0);
        tick();
        drv(1'b1, SUBU7, 1'b0, 1'b0);
        tick();
        drv(1'b1, JAL, 1'b0, 1'b0);
        tick();
        chk("mid_inflight", 64'(stg_valid), 64'd7);
        reset = 1'b1;
        drv(1'b1, ADDU3, 1'b0, 1'b0);
        tick();
        chk("mid_rst_valid", 64'(stg_valid), 64'd0);
        chk("mid_rst_ctrl", 64'(stg_ctrl), 64'd0);
        chk("mid_rst_dest", 64'(stg_dest), 64'd0);
        reset = 1'b0;
        #1;
        tick();
        chk("post_rst_valid", 64'(stg_valid), 64'b001);
        chk("post_rst_dest", 64'(ds(0)), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
